mem_lsu: RTL

Memory-access stage. It sits between the ex_mem pipeline register and the mem_wb register.
- Non-memory instructions pass straight through to the mem_wb inputs.
- Loads and stores run a request/acknowledge transaction to data RAM. The stage raises stallreq until the transaction completes or times out.
- Load data is extracted big-endian, with byte/halfword sign or zero extension.
- Misaligned accesses and bus timeouts are reported as one-cycle exception flags.

---
 rtl/mem_lsu.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through to mem_wb and runs a
// request/acknowledge transaction to data RAM for loads and stores.
module mem_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic        stall_hold,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        stallreq,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        excp_misalign,
  output logic        excp_buserr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  lat_wd_q, lat_wd_d;
  logic        lat_wreg_q, lat_wreg_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [31:0] lat_hi_q, lat_hi_d;
  logic [31:0] lat_lo_q, lat_lo_d;
  logic        lat_whilo_q, lat_whilo_d;

  logic        is_byte, is_half, is_word, is_load, is_store;
  logic        misalign, access;
  logic [3:0]  sel;
  logic [31:0] bus_wdata;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  logic [4:0]  o_wd;
  logic        o_wreg;
  logic [31:0] o_wdata;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_whilo;
  logic        o_req;
  logic        o_stall;
  logic        o_misalign;
  logic        o_buserr;
  logic        done;

  // Opcode decode, alignment check and big-endian lane selection.
  always_comb begin
    is_byte  = (ex_memop == 4'd1) || (ex_memop == 4'd2) || (ex_memop == 4'd6);
    is_half  = (ex_memop == 4'd3) || (ex_memop == 4'd4) || (ex_memop == 4'd7);
    is_word  = (ex_memop == 4'd5) || (ex_memop == 4'd8);
    is_load  = (ex_memop >= 4'd1) && (ex_memop <= 4'd5);
    is_store = (ex_memop >= 4'd6) && (ex_memop <= 4'd8);
    misalign = (is_half && ex_addr[0]) || (is_word && (ex_addr[1:0] != 2'b00));
    access   = (is_load || is_store) && !misalign;

    sel = 4'b1111;
    if (is_byte)      sel = 4'b1000 >> ex_addr[1:0];
    else if (is_half) sel = ex_addr[1] ? 4'b0011 : 4'b1100;

    bus_wdata = ex_wdata;
    if (is_byte)      bus_wdata = {4{ex_wdata[7:0]}};
    else if (is_half) bus_wdata = {2{ex_wdata[15:0]}};

    case (ex_addr[1:0])
      2'd0:    byte_lane = ram_rdata[31:24];
      2'd1:    byte_lane = ram_rdata[23:16];
      2'd2:    byte_lane = ram_rdata[15:8];
      default: byte_lane = ram_rdata[7:0];
    endcase
    half_lane = ex_addr[1] ? ram_rdata[15:0] : ram_rdata[31:16];

    case (ex_memop)
      4'd1:    load_data = {{24{byte_lane[7]}}, byte_lane};
      4'd2:    load_data = {24'd0, byte_lane};
      4'd3:    load_data = {{16{half_lane[15]}}, half_lane};
      4'd4:    load_data = {16'd0, half_lane};
      default: load_data = ram_rdata;
    endcase
  end

  // Transaction control; `done` marks any completion or abort cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_wd        = ex_wd;
    o_wreg      = ex_wreg && !is_store;
    o_wdata     = ex_wdata;
    o_hi        = ex_hi;
    o_lo        = ex_lo;
    o_whilo     = ex_whilo;
    o_req       = 1'b0;
    o_stall     = 1'b0;
    o_misalign  = 1'b0;
    o_buserr    = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (misalign && (is_load || is_store)) begin
          o_misalign = 1'b1;
          o_wreg     = 1'b0;
          done       = 1'b1;
        end else if (access) begin
          o_req = 1'b1;
          if (ram_ack) begin
            if (is_load) o_wdata = load_data;
            done = 1'b1;
          end else begin
            o_stall = 1'b1;
            state_d = S_WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      S_WAIT: begin
        o_req = 1'b1;
        if (ram_ack) begin
          if (is_load) o_wdata = load_data;
          done = 1'b1;
        end else if (cnt_q == LAST_WAIT) begin
          o_req    = 1'b0;
          o_buserr = 1'b1;
          o_wreg   = 1'b0;
          done     = 1'b1;
        end else begin
          o_stall = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        o_wd    = lat_wd_q;
        o_wreg  = lat_wreg_q;
        o_wdata = lat_wdata_q;
        o_hi    = lat_hi_q;
        o_lo    = lat_lo_q;
        o_whilo = lat_whilo_q;
        if (!stall_hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      cnt_d   = 8'd0;
      state_d = stall_hold ? S_HOLD : S_IDLE;
    end

    lat_wd_d    = done ? o_wd    : lat_wd_q;
    lat_wreg_d  = done ? o_wreg  : lat_wreg_q;
    lat_wdata_d = done ? o_wdata : lat_wdata_q;
    lat_hi_d    = done ? o_hi    : lat_hi_q;
    lat_lo_d    = done ? o_lo    : lat_lo_q;
    lat_whilo_d = done ? o_whilo : lat_whilo_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      lat_wd_q    <= 5'd0;
      lat_wreg_q  <= 1'b0;
      lat_wdata_q <= 32'd0;
      lat_hi_q    <= 32'd0;
      lat_lo_q    <= 32'd0;
      lat_whilo_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_wd_q    <= lat_wd_d;
      lat_wreg_q  <= lat_wreg_d;
      lat_wdata_q <= lat_wdata_d;
      lat_hi_q    <= lat_hi_d;
      lat_lo_q    <= lat_lo_d;
      lat_whilo_q <= lat_whilo_d;
    end
  end

  // Everything is forced low while reset is held, so a pending request drops at once.
  always_comb begin
    mem_wd        = rst ? o_wd       : 5'd0;
    mem_wreg      = rst && o_wreg;
    mem_wdata     = rst ? o_wdata    : 32'd0;
    mem_hi        = rst ? o_hi       : 32'd0;
    mem_lo        = rst ? o_lo       : 32'd0;
    mem_whilo     = rst && o_whilo;
    stallreq      = rst && o_stall;
    ram_req       = rst && o_req;
    ram_we        = rst && o_req && is_store;
    ram_addr      = (rst && o_req) ? {ex_addr[31:2], 2'b00} : 32'd0;
    ram_sel       = (rst && o_req) ? sel : 4'd0;
    ram_wdata     = (rst && o_req && is_store) ? bus_wdata : 32'd0;
    excp_misalign = rst && o_misalign;
    excp_buserr   = rst && o_buserr;
  end

endmodule
